me_result_seq: RTL
==================

ME_RESULT_SEQ -- requirements
Module: me_result_seq

Interface
REQ-001 Parameter NUM_BLK, default 16, number of template blocks searched per frame (1..256).
REQ-002 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 Parameter SAD_THRESH, default 16'd1024, skip threshold (used only with ME_SKIP_FLAG_EN).
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle pulse, begin a frame of NUM_BLK searches.
REQ-007 busy  out  1  high from accepted start until frame done.
REQ-008 done  out  1  one-cycle pulse after last block's handshake completes.
REQ-009 blk_idx  out  8  index of block currently being searched, drives memory bank select.
REQ-010 me_req  out  1  request to motion-estimation core.
REQ-011 me_ack  in  1  core completion, held high until me_req drops.
REQ-012 me_min_sad  in  16  minimum SAD from core, valid while me_ack=1.
REQ-013 me_min_mvec  in  12  {h[5:0], w[5:0]} motion vector, valid while me_ack=1.
REQ-014 res_valid  out  1  FIFO not empty.
REQ-015 res_ready  in  1  consumer accepts head entry when res_valid&res_ready.
REQ-016 res_sad / res_mvec / res_blk  out  16 / 12 / 8  head entry fields.
REQ-017 res_last  out  1  head entry is block NUM_BLK-1.

Function
REQ-018 FSM states IDLE, WAIT_SPACE, REQ, REL; encoding free.
REQ-019 IDLE: start=1 -> blk_idx<=0, busy<=1, go WAIT_SPACE; start ignored in all other states.
REQ-020 WAIT_SPACE: FIFO not full -> REQ; me_req=0 in this state.
REQ-021 REQ: me_req=1 registered; first cycle me_ack=1 -> push {me_min_sad, me_min_mvec, blk_idx, last} into FIFO, go REL.
REQ-022 REL: me_req=0; wait me_ack=0; then if blk_idx==NUM_BLK-1 -> done pulse, busy<=0, IDLE; else blk_idx+1, WAIT_SPACE.
REQ-023 Exactly one FIFO push per block; me_ack remaining high in REL causes no further push.
REQ-024 Space check precedes me_req, so push never occurs on full FIFO.
REQ-025 Pop on res_valid&res_ready; pop on empty FIFO is a no-op.
REQ-026 Simultaneous push and pop permitted at any occupancy incl. full; count unchanged.
REQ-027 Read/write pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-028 Head fields drive outputs combinationally from storage; res_* stable while res_valid&~res_ready.
REQ-029 Head fields undefined-but-stable (hold last value) when res_valid=0; consumers must not sample.
REQ-030 blk_idx wraps never within a frame; NUM_BLK=1 yields one search then done.

Reset
REQ-031 rst_n=0 asynchronously: FSM IDLE, me_req=0, busy=0, done=0, blk_idx=0, FIFO pointers/count=0, res_valid=0.
REQ-032 Reset mid-frame abandons the search; core handshake restarts only after next start.
REQ-033 FIFO storage array not reset.

Configuration
REQ-034 Macro ME_SKIP_FLAG_EN defined: extra output res_skip (1 bit) stored per entry, 1 when me_min_sad > SAD_THRESH, else 0.
REQ-035 Macro ME_SKIP_FLAG_EN undefined: no res_skip port, no comparator, entry width 37 bits.

Verification
REQ-036 NUM_BLK=4, core model acks 20 cycles after req, res_ready=1 -> 4 entries blk 0..3, res_last only on blk 3, one done pulse, busy low after.
REQ-037 res_ready=0, NUM_BLK=8, FIFO_DEPTH=4 -> exactly 4 pushes, FSM parks in WAIT_SPACE with me_req=0; raise res_ready -> remaining 4 blocks complete in order.
REQ-038 Core holds me_ack high 10 cycles after me_req falls -> single push per block, next me_req not asserted until me_ack=0.
REQ-039 rst_n low during REQ of block 2 -> me_req=0, res_valid=0, blk_idx=0 immediately; start re-issued -> block 0 searched again.
REQ-040 Full FIFO with res_ready=1 on same cycle as push -> count stays 4, ordering preserved, no entry lost.
REQ-041 ME_SKIP_FLAG_EN, SAD_THRESH=1024: core returns sad 1024 then 1025 -> res_skip 0 then 1.

Source files
------------

// File: rtl/me_result_seq.sv
// Motion-estimation result sequencer: walks NUM_BLK blocks per frame through a
// req/ack core handshake and queues results in a FIFO. Optional ME_SKIP_FLAG_EN adds res_skip.
module me_result_seq #(
    parameter int unsigned NUM_BLK    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] SAD_THRESH = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [7:0]  blk_idx,
    output logic        me_req,
    input  logic        me_ack,
    input  logic [15:0] me_min_sad,
    input  logic [11:0] me_min_mvec,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_sad,
    output logic [11:0] res_mvec,
    output logic [7:0]  res_blk,
    output logic        res_last
`ifdef ME_SKIP_FLAG_EN
    ,
    output logic        res_skip
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] LAST_BLK = 8'(NUM_BLK - 1);
`ifdef ME_SKIP_FLAG_EN
    localparam int EW = 38;
`else
    localparam int EW = 37;
`endif

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, REL} state_t;

    state_t          state, state_nxt;
    logic            push, wr_en, pop, full, last_blk;
    logic            frame_start, frame_end, blk_inc;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [EW-1:0]   wdata, head;
    logic [EW-1:0]   mem [FIFO_DEPTH];

    assign last_blk  = (blk_idx == LAST_BLK);
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign res_valid = (count != '0);
    assign pop       = res_valid & res_ready;
    // Full-with-pop still has a free slot by the time the write lands
    assign wr_en     = push & (~full | pop);

    always_comb begin
        state_nxt   = state;
        push        = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        blk_inc     = 1'b0;
        case (state)
            IDLE: if (start) begin
                frame_start = 1'b1;
                state_nxt   = WAIT_SPACE;
            end
            WAIT_SPACE: if (!full) state_nxt = REQ;
            REQ: if (me_ack) begin
                push      = 1'b1;
                state_nxt = REL;
            end
            REL: if (!me_ack) begin
                if (last_blk) begin
                    frame_end = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    blk_inc   = 1'b1;
                    state_nxt = WAIT_SPACE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            me_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            blk_idx <= '0;
        end else begin
            state  <= state_nxt;
            me_req <= (state_nxt == REQ);
            done   <= frame_end;
            if (frame_start) begin
                blk_idx <= '0;
                busy    <= 1'b1;
            end else if (blk_inc) begin
                blk_idx <= blk_idx + 8'd1;
            end
            if (frame_end) busy <= 1'b0;
        end
    end

`ifdef ME_SKIP_FLAG_EN
    assign wdata = {me_min_sad > SAD_THRESH, me_min_sad, me_min_mvec, blk_idx, last_blk};
`else
    assign wdata = {me_min_sad, me_min_mvec, blk_idx, last_blk};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left unreset; res_valid gates its use
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];
    assign {res_sad, res_mvec, res_blk, res_last} = head[36:0];
`ifdef ME_SKIP_FLAG_EN
    assign res_skip = head[37];
`endif

endmodule
